// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Requester and transmitter signal bundle for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   err;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 active;

    // Requesters plus transmitter: drives requests and busy, observes results.
    modport master (
        output req, req_data, tx_busy,
        input  ack, err, grant, tx_data, tx_start, active
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, tx_busy,
        output ack, err, grant, tx_data, tx_start, active
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Round-robin sharing of one 8N1 UART transmitter among NUM_REQ requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 2047
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [c_PTR_W:0]   c_NUM      = (c_PTR_W + 1)'(NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ARB       = 3'd1;
    localparam logic [2:0] c_START     = 3'd2;
    localparam logic [2:0] c_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_DONE      = 3'd5;
    localparam logic [2:0] c_ABORT     = 3'd6;

    logic [2:0]         state_q,   state_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [c_PTR_W-1:0] ptr_q,     ptr_d;
    logic [c_CNT_W-1:0] cnt_q,     cnt_d;

    logic [NUM_REQ-1:0] w_win_oh;
    logic [7:0]         w_win_data;
    logic [c_PTR_W-1:0] w_win_nxt;
    logic [c_PTR_W:0]   w_sum;
    logic [c_PTR_W-1:0] w_idx;

    // Round-robin search: offsets 0..NUM_REQ-1 from ptr, first set bit wins.
    always_comb begin
        w_win_oh   = '0;
        w_win_data = '0;
        w_win_nxt  = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, ptr_q} + (c_PTR_W + 1)'(i);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            w_idx = w_sum[c_PTR_W-1:0];
            if (w_win_oh == '0 && bus.req[w_idx]) begin
                w_win_oh[w_idx] = 1'b1;
                w_win_data      = bus.req_data[{w_idx, 3'b000} +: 8];
                w_win_nxt       = (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            grant_q   <= '0;
            tx_data_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            c_IDLE: begin
                // A frame left over from a reset must drain before a new grant.
                if (!bus.tx_busy && (|bus.req)) begin
                    state_d = c_ARB;
                end
            end
            c_ARB: begin
                if (|bus.req) begin
                    grant_d   = w_win_oh;
                    tx_data_d = w_win_data;
                    ptr_d     = w_win_nxt;
                    state_d   = c_START;
                end else begin
                    state_d = c_IDLE;
                end
            end
            c_START: begin
                cnt_d   = '0;
                state_d = c_WAIT_BUSY;
            end
            c_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = c_WAIT_DONE;
                end else if (cnt_q >= c_CNT_LAST) begin
                    state_d = c_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = c_DONE;
                end
            end
            c_DONE, c_ABORT: begin
                grant_d = '0;
                state_d = c_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.grant    = grant_q;
        bus.tx_data  = tx_data_q;
        bus.tx_start = (state_q == c_START);
        bus.ack      = (state_q == c_DONE)  ? grant_q : '0;
        bus.err      = (state_q == c_ABORT) ? grant_q : '0;
        bus.active   = (state_q != c_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with a UART model and serial scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 2047;
    localparam int BIT     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Transmitter model: shortened bit period, latches data on tx_start rising edge.
    logic       m_busy     = 1'b0;
    logic       m_sd       = 1'b0;
    logic       line       = 1'b1;
    logic       force_busy = 1'b0;
    logic       model_en   = 1'b1;
    logic [9:0] m_sh       = '0;
    int         m_bits     = 0;
    int         m_cnt      = 0;

    assign bus.tx_busy = m_busy | force_busy;

    always @(posedge clk) begin
        m_sd <= bus.tx_start;
        if (!m_busy) begin
            if (model_en && bus.tx_start && !m_sd) begin
                m_busy <= 1'b1;
                m_sh   <= {1'b1, bus.tx_data, 1'b0};
                m_bits <= 10;
                m_cnt  <= BIT - 1;
                line   <= 1'b0;
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else if (m_bits == 1) begin
            m_busy <= 1'b0;
            line   <= 1'b1;
        end else begin
            m_sh   <= m_sh >> 1;
            line   <= m_sh[1];
            m_bits <= m_bits - 1;
            m_cnt  <= BIT - 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitors sampled mid-cycle.
    int   dbl_start  = 0;
    int   bad_start  = 0;
    int   bad_out    = 0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_start && prev_start) dbl_start <= dbl_start + 1;
        if (bus.tx_start && bus.tx_busy) bad_start <= bad_start + 1;
        if ((bus.ack != '0 && bus.err != '0) || $countones(bus.ack) > 1 ||
            $countones(bus.err) > 1) bad_out <= bad_out + 1;
        prev_start <= bus.tx_start;
    end

    // Serial receiver: decodes each frame and pops the expected byte.
    initial begin : rx_proc
        logic [7:0] b;
        logic       st;
        logic       sb;
        forever begin
            @(negedge clk);
            if (line === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                st = line;
                for (int k = 0; k < 8; k++) begin
                    repeat (BIT) @(negedge clk);
                    b[k] = line;
                end
                repeat (BIT) @(negedge clk);
                sb = line;
                chk("rx_start_bit", 32'(st), 0);
                chk("rx_stop_bit", 32'(sb), 1);
                chk("rx_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
            end
        end
    end

    // Runs one frame to its ack and checks grant, data, stability and ack timing.
    task automatic wait_ack(input int idx, input logic [7:0] exp_data,
                            input bit drop_mid, output int start_cyc);
        int cyc;
        int fall;
        bit seen;
        bit stable;
        bit got;
        logic [7:0]         d0;
        logic [NUM_REQ-1:0] g0;
        logic [NUM_REQ-1:0] a;
        logic [NUM_REQ-1:0] e;
        logic               pb;
        cyc = 0; fall = -100; seen = 0; stable = 1; got = 0;
        d0 = '0; g0 = '0; a = '0; e = '0; pb = bus.tx_busy; start_cyc = -1;
        while (!got && cyc < 400) begin
            tick();
            cyc++;
            if (bus.tx_start) begin
                seen = 1; d0 = bus.tx_data; g0 = bus.grant; start_cyc = cyc;
            end else if (seen && bus.grant != '0 && bus.tx_data !== d0) begin
                stable = 0;
            end
            if (drop_mid && seen && bus.tx_busy) bus.req[idx] = 1'b0;
            if (pb && !bus.tx_busy) fall = cyc;
            pb = bus.tx_busy;
            if (bus.ack != '0 || bus.err != '0) begin
                got = 1; a = bus.ack; e = bus.err;
            end
        end
        chk("done_seen", 32'(got), 1);
        chk("ack_vec", 32'(a), 32'(1) << idx);
        chk("err_vec", 32'(e), 0);
        chk("grant_at_start", 32'(g0), 32'(1) << idx);
        chk("tx_data", 32'(d0), 32'(exp_data));
        chk("tx_data_stable", 32'(stable), 1);
        chk("ack_latency", 32'(cyc - fall), 1);
        bus.req[idx] = 1'b0;
        tick();
        chk("idle_after_done", 32'({bus.grant, bus.active}), 0);
    endtask

    initial begin : watchdog
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: observed no finish expected finish within 50000 cycles");
        $fatal(1);
    end

    initial begin : main
        int sc;
        int c;
        int s_c;
        int e_c;
        bit ack_seen;
        logic [NUM_REQ-1:0] ev;

        bus.req      = '0;
        bus.req_data = '0;
        rst          = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", 32'({bus.grant, bus.ack, bus.err, bus.tx_data,
                                  bus.tx_start, bus.active}), 0);
        rst = 1'b0;
        tick();
        chk("idle_no_req", 32'({bus.grant, bus.active, bus.tx_start}), 0);

        // Single request.
        bus.req_data[7:0] = 8'hA5;
        bus.req           = 4'b0001;
        exp_q.push_back(8'hA5);
        wait_ack(0, 8'hA5, 0, sc);
        chk("start_latency", 32'(sc), 2);

        // All four requesting from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req      = 4'b1111;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        wait_ack(0, 8'h11, 0, sc);
        bus.req[0] = 1'b1;
        exp_q.push_back(8'h11);
        wait_ack(1, 8'h22, 1, sc);
        wait_ack(2, 8'h33, 0, sc);
        wait_ack(3, 8'h44, 0, sc);
        wait_ack(0, 8'h11, 0, sc);

        // Stuck transmitter: requester 1 times out, requester 2 is served next.
        model_en           = 1'b0;
        bus.req_data[15:8] = 8'h5A;
        bus.req_data[23:16] = 8'h3C;
        bus.req            = 4'b0110;
        s_c = -1; e_c = -1; ack_seen = 0; ev = '0; c = 0;
        while (e_c < 0 && c < 2400) begin
            tick();
            c++;
            if (bus.tx_start) s_c = c;
            if (bus.ack != '0) ack_seen = 1;
            if (bus.err != '0) begin
                e_c = c; ev = bus.err;
            end
        end
        chk("timeout_err_vec", 32'(ev), 32'h2);
        chk("timeout_latency", 32'(e_c - s_c), 32'(TIMEOUT + 1));
        chk("timeout_no_ack", 32'(ack_seen), 0);
        bus.req[1] = 1'b0;
        model_en   = 1'b1;
        exp_q.push_back(8'h3C);
        wait_ack(2, 8'h3C, 0, sc);

        // Reset in the middle of a frame.
        bus.req_data[7:0] = 8'h77;
        bus.req           = 4'b0001;
        exp_q.push_back(8'h77);
        c = 0;
        while (!(bus.tx_busy && bus.grant == 4'b0001) && c < 200) begin
            tick();
            c++;
        end
        chk("frame_running", 32'(bus.tx_busy && bus.grant == 4'b0001), 1);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("midframe_reset_outputs", 32'({bus.grant, bus.ack, bus.err, bus.tx_data,
                                           bus.tx_start, bus.active}), 0);
        rst = 1'b0;
        chk("busy_at_release", 32'(bus.tx_busy), 1);
        exp_q.push_back(8'h77);
        wait_ack(0, 8'h77, 0, sc);
        chk("start_after_busy_drains", 32'(sc > 20), 1);

        // Busy already high when reset releases.
        rst               = 1'b1;
        force_busy        = 1'b1;
        bus.req_data[7:0] = 8'hC3;
        bus.req           = 4'b0001;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("held_off_by_busy", 32'({bus.active, bus.tx_start, bus.grant}), 0);
        force_busy = 1'b0;
        exp_q.push_back(8'hC3);
        wait_ack(0, 8'hC3, 0, sc);
        chk("latency_after_busy_low", 32'(sc), 2);

        repeat (BIT * 12) tick();
        chk("rx_drained", 32'(exp_q.size()), 0);
        chk("tx_start_single_cycle", 32'(dbl_start), 0);
        chk("tx_start_while_busy", 32'(bad_start), 0);
        chk("ack_err_exclusive", 32'(bad_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
